tlb_miss_walker: RTL and testbench

- Hardware page-table walker that sits directly upstream of the TLB write port.
- On a TLB miss it fetches the single-level page-table entry (PTE) from memory.
- If the PTE is valid, it issues a one-cycle TLB fill (write, vaddr, paddr_new). If not, it reports a fault.
- Memory-side requests go through a simple req/ready read port.

---
 rtl/tlb_miss_walker_pkg.sv | 20 ++
 rtl/tlb_miss_walker_if.sv | 37 +++
 rtl/tlb_walk_timeout.sv | 32 +++
 rtl/tlb_miss_walker.sv | 149 ++++++++++++++
 tb/tb_tlb_miss_walker.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/tlb_miss_walker_pkg.sv
// Shared widths, PTE field positions and walker state encodings.
// Imported by the walker interface, the walker top and its watchdog.
// Holds no logic of its own.
package tlb_miss_walker_pkg;

    localparam int VIRTUAL_ADDR_WIDTH  = 32;
    localparam int PHYSICAL_ADDR_WIDTH = 20;
    localparam int PAGE_OFFSET_WIDTH   = 12;

    // Bit 31 of a PTE marks the mapping as present.
    localparam int PTE_VALID_BIT       = 31;

    typedef enum logic [1:0] {
        WALK_IDLE  = 2'd0,
        WALK_REQ   = 2'd1,
        WALK_WRITE = 2'd2,
        WALK_FAULT = 2'd3
    } walk_state_t;

endpackage

// File: rtl/tlb_miss_walker_if.sv
// Miss request, PTE read port and TLB fill port of the page-table walker.
// The slave modport is the walker; the master modport is the requester/memory/TLB side.
// No storage: plain wires grouped for port connection.
interface tlb_miss_walker_if
    import tlb_miss_walker_pkg::*;
#(
    parameter int VADDR_W = VIRTUAL_ADDR_WIDTH,
    parameter int PADDR_W = PHYSICAL_ADDR_WIDTH
) ();

    logic               miss_valid;
    logic [VADDR_W-1:0] miss_vaddr;
    logic [PADDR_W-1:0] ptbr;
    logic               busy;

    logic               mem_req;
    logic [PADDR_W-1:0] mem_addr;
    logic [31:0]        mem_rdata;
    logic               mem_ready;

    logic               tlb_write;
    logic [VADDR_W-1:0] tlb_vaddr;
    logic [PADDR_W-1:0] tlb_paddr_new;
    logic               done;
    logic               fault;

    modport slave (
        input  miss_valid, miss_vaddr, ptbr, mem_rdata, mem_ready,
        output busy, mem_req, mem_addr, tlb_write, tlb_vaddr, tlb_paddr_new, done, fault
    );

    modport master (
        output miss_valid, miss_vaddr, ptbr, mem_rdata, mem_ready,
        input  busy, mem_req, mem_addr, tlb_write, tlb_vaddr, tlb_paddr_new, done, fault
    );

endinterface

// File: rtl/tlb_walk_timeout.sv
// Watchdog for an outstanding PTE read: counts REQ cycles that end without a response.
// o_expired is combinational: high during the LIMIT-th consecutive waiting cycle.
// Clear has priority over enable; count stops once the walker leaves REQ.
module tlb_walk_timeout #(
    parameter int unsigned LIMIT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;

    logic [CNT_W-1:0] r_cnt;

    // Count waiting cycles; restart whenever a new walk is accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Terminal count: this waiting cycle is the LIMIT-th one.
    assign o_expired = i_enable && (r_cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/tlb_miss_walker.sv
// Single-level page-table walker feeding the TLB write port; optional read watchdog under MISS_TIMEOUT_EN.
// Latency with zero-wait memory: accept edge N, mem_req in N+1, fill/fault in N+2, idle in N+3.
// Holds mem_req/mem_addr until mem_ready; ignores miss_valid while busy and mem_ready outside REQ.
module tlb_miss_walker
    import tlb_miss_walker_pkg::*;
#(
    parameter int          VADDR_W        = VIRTUAL_ADDR_WIDTH,
    parameter int          PADDR_W        = PHYSICAL_ADDR_WIDTH,
    parameter int          PAGE_OFFSET_W  = PAGE_OFFSET_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,
    tlb_miss_walker_if.slave  io_walk
);

    localparam int VPN_W = VADDR_W - PAGE_OFFSET_W;
    localparam int PPN_W = PADDR_W - PAGE_OFFSET_W;

    walk_state_t        r_state;
    walk_state_t        w_state_nxt;

    logic [VADDR_W-1:0] r_vaddr;
    logic [PADDR_W-1:0] r_pte_addr;
    logic [VADDR_W-1:0] r_tlb_vaddr;
    logic [PADDR_W-1:0] r_tlb_paddr;

    logic [VPN_W-1:0]   w_vpn;
    logic [PADDR_W-1:0] w_pte_addr;
    logic               w_accept;
    logic               w_pte_valid;
    logic               w_fill;
    logic               w_req_wait;
    logic               w_expired;

    logic               w_busy;
    logic               w_mem_req;
    logic               w_tlb_write;
    logic               w_fault;

    // PTE bits between the PPN and the valid bit are reserved.
    logic               w_unused_pte;
    assign w_unused_pte = ^io_walk.mem_rdata[PTE_VALID_BIT-1:PPN_W];

    // Each PTE is one 32-bit word; the address wraps modulo the physical space.
    assign w_vpn       = io_walk.miss_vaddr[VADDR_W-1:PAGE_OFFSET_W];
    assign w_pte_addr  = io_walk.ptbr + PADDR_W'({w_vpn, 2'b00});

    assign w_accept    = (r_state == WALK_IDLE) && io_walk.miss_valid;
    assign w_pte_valid = io_walk.mem_rdata[PTE_VALID_BIT];
    assign w_fill      = (r_state == WALK_REQ) && io_walk.mem_ready && w_pte_valid;
    assign w_req_wait  = (r_state == WALK_REQ) && !io_walk.mem_ready;

`ifdef MISS_TIMEOUT_EN
    tlb_walk_timeout #(
        .LIMIT     (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_reset),
        .i_clear   (w_accept),
        .i_enable  (w_req_wait),
        .o_expired (w_expired)
    );
`else
    // Without the watchdog a read may stall forever; only invalid PTEs fault.
    logic [31:0] w_unused_timeout;
    logic        w_unused_wait;
    assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
    assign w_unused_wait    = w_req_wait;
    assign w_expired        = 1'b0;
`endif

    // State register; reset returns to IDLE so an in-flight response is dropped.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= WALK_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded outputs; outputs follow the state so reset clears them at once.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_mem_req   = 1'b0;
        w_tlb_write = 1'b0;
        w_fault     = 1'b0;
        case (r_state)
            WALK_IDLE: begin
                if (io_walk.miss_valid) begin
                    w_state_nxt = WALK_REQ;
                end
            end
            WALK_REQ: begin
                w_busy    = 1'b1;
                w_mem_req = 1'b1;
                // A response on the terminal watchdog edge still completes the walk.
                if (io_walk.mem_ready) begin
                    w_state_nxt = w_pte_valid ? WALK_WRITE : WALK_FAULT;
                end else if (w_expired) begin
                    w_state_nxt = WALK_FAULT;
                end
            end
            WALK_WRITE: begin
                w_busy      = 1'b1;
                w_tlb_write = 1'b1;
                w_state_nxt = WALK_IDLE;
            end
            WALK_FAULT: begin
                w_busy      = 1'b1;
                w_fault     = 1'b1;
                w_state_nxt = WALK_IDLE;
            end
            default: begin
                w_state_nxt = WALK_IDLE;
            end
        endcase
    end

    // Capture the miss on accept; load the fill registers only when a valid PTE returns.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_vaddr     <= '0;
            r_pte_addr  <= '0;
            r_tlb_vaddr <= '0;
            r_tlb_paddr <= '0;
        end else begin
            if (w_accept) begin
                r_vaddr    <= io_walk.miss_vaddr;
                r_pte_addr <= w_pte_addr;
            end
            if (w_fill) begin
                r_tlb_vaddr <= r_vaddr;
                r_tlb_paddr <= {io_walk.mem_rdata[PPN_W-1:0], r_vaddr[PAGE_OFFSET_W-1:0]};
            end
        end
    end

    assign io_walk.busy          = w_busy;
    assign io_walk.mem_req       = w_mem_req;
    assign io_walk.mem_addr      = r_pte_addr;
    assign io_walk.tlb_write     = w_tlb_write;
    assign io_walk.done          = w_tlb_write;
    assign io_walk.fault         = w_fault;
    assign io_walk.tlb_vaddr     = r_tlb_vaddr;
    assign io_walk.tlb_paddr_new = r_tlb_paddr;

endmodule

// File: tb/tb_tlb_miss_walker.sv
// Bench for tlb_miss_walker: directed walks, randomized walks and reset mid-walk.
// Expected addresses, outcomes and cycle counts come from a transaction-level model.
// Inputs change #1 after posedge; outputs are sampled on negedge.
module tb_tlb_miss_walker;

    localparam int TO = 16;

    logic clk;
    logic reset;

    int n_chk;
    int n_bad;

    // Model of the values the fill port should be holding.
    logic [31:0] last_va;
    logic [19:0] last_pa;

    tlb_miss_walker_if #(.VADDR_W(32), .PADDR_W(20)) bus ();

    tlb_miss_walker #(
        .VADDR_W        (32),
        .PADDR_W        (20),
        .PAGE_OFFSET_W  (12),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_walk (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    // One complete walk: present the miss in an idle cycle, answer after wait_n REQ cycles.
    task automatic do_walk(input logic [31:0] va, input logic [19:0] pb,
                           input logic [31:0] pte, input int wait_n, input bit wiggle);
        logic [31:0] sum;
        logic [19:0] exp_addr;
        logic [19:0] exp_pa;
        int          nreq;
        bit          fill;
        sum      = 32'(pb) + (va >> 12) * 4;
        exp_addr = sum[19:0];
        exp_pa   = {pte[7:0], va[11:0]};
        nreq     = wait_n + 1;
        fill     = pte[31];
`ifdef MISS_TIMEOUT_EN
        if (nreq > TO) begin
            nreq = TO;
            fill = 1'b0;
        end
`endif
        @(posedge clk); #1;
        bus.miss_valid = 1'b1;
        bus.miss_vaddr = va;
        bus.ptbr       = pb;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = $urandom;
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        for (int k = 0; k < nreq; k++) begin
            @(posedge clk); #1;
            bus.mem_ready = (k == wait_n);
            bus.mem_rdata = (k == wait_n) ? pte : $urandom;
            if (wiggle) begin
                bus.miss_valid = (k % 2 == 1);
                bus.miss_vaddr = $urandom;
                bus.ptbr       = 20'($urandom);
            end
            @(negedge clk);
            chk("req_mem_req", 32'(bus.mem_req), 32'd1);
            chk("req_mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
            chk("req_busy", 32'(bus.busy), 32'd1);
            chk("req_no_write", 32'(bus.tlb_write | bus.done | bus.fault), 32'd0);
        end
        @(posedge clk); #1;
        bus.mem_ready  = 1'b0;
        bus.miss_valid = 1'b0;
        @(negedge clk);
        if (fill) begin
            last_va = va;
            last_pa = exp_pa;
        end
        chk("end_tlb_write", 32'(bus.tlb_write), 32'(fill));
        chk("end_done", 32'(bus.done), 32'(fill));
        chk("end_fault", 32'(bus.fault), 32'(!fill));
        chk("end_mem_req", 32'(bus.mem_req), 32'd0);
        chk("end_tlb_vaddr", bus.tlb_vaddr, last_va);
        chk("end_tlb_paddr", 32'(bus.tlb_paddr_new), 32'(last_pa));
        @(posedge clk);
        @(negedge clk);
        chk("after_busy", 32'(bus.busy), 32'd0);
        chk("after_pulses", 32'(bus.tlb_write | bus.done | bus.fault | bus.mem_req), 32'd0);
        chk("hold_tlb_vaddr", bus.tlb_vaddr, last_va);
        chk("hold_tlb_paddr", 32'(bus.tlb_paddr_new), 32'(last_pa));
    endtask

    initial begin
        n_chk          = 0;
        n_bad          = 0;
        last_va        = '0;
        last_pa        = '0;
        reset          = 1'b0;
        bus.miss_valid = 1'b0;
        bus.miss_vaddr = '0;
        bus.ptbr       = '0;
        bus.mem_rdata  = '0;
        bus.mem_ready  = 1'b0;

        // Reset state.
        #12;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_pulses", 32'(bus.tlb_write | bus.done | bus.fault), 32'd0);
        chk("rst_tlb_vaddr", bus.tlb_vaddr, 32'd0);
        chk("rst_tlb_paddr", 32'(bus.tlb_paddr_new), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Valid fill with zero wait, then invalid PTE.
        do_walk(32'h0000_1012, 20'h08000, 32'h8000_00F1, 0, 1'b0);
        do_walk(32'h0000_2123, 20'h08000, 32'h0000_00F2, 0, 1'b0);
        // Five wait states with miss_valid and inputs toggling during the walk.
        do_walk(32'h0003_4567, 20'h12340, 32'hC5A5_5A3C, 5, 1'b1);
        // PTE address wraps around the physical space.
        do_walk(32'h0000_2000, 20'hFFFFC, 32'h8000_0077, 0, 1'b0);

        // Randomized walks.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] rva;
            logic [31:0] rpte;
            rva  = $urandom;
            rpte = $urandom;
            rpte[31] = ($urandom_range(0, 2) != 0);
            do_walk(rva, 20'($urandom), rpte, int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)));
        end

`ifdef MISS_TIMEOUT_EN
        // No response at all, then a response on the terminal watchdog edge.
        do_walk(32'h0000_5123, 20'h04000, 32'h8000_0011, 1000, 1'b0);
        do_walk(32'h0000_6123, 20'h04000, 32'h8000_0022, TO - 1, 1'b0);
`endif

        // Reset during REQ with a valid response pending.
        @(posedge clk); #1;
        bus.miss_valid = 1'b1;
        bus.miss_vaddr = 32'h0000_7abc;
        bus.ptbr       = 20'h00100;
        @(posedge clk); #1;
        bus.miss_valid = 1'b0;
        bus.mem_ready  = 1'b1;
        bus.mem_rdata  = 32'h8000_0033;
        #2;
        reset = 1'b0;
        last_va = '0;
        last_pa = '0;
        #1;
        chk("midrst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_tlb_vaddr", bus.tlb_vaddr, last_va);
        chk("midrst_tlb_paddr", 32'(bus.tlb_paddr_new), 32'(last_pa));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("postrst_busy", 32'(bus.busy), 32'd0);
            chk("postrst_pulses", 32'(bus.tlb_write | bus.done | bus.fault | bus.mem_req), 32'd0);
        end
        bus.mem_ready = 1'b0;

        // A fresh walk works after the mid-walk reset.
        do_walk(32'h0000_3fff, 20'h00200, 32'h8000_00AB, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
